embertrail_dmem: RTL and testbench

EMBERTRAIL_DMEM -- requirements
Module: embertrail_dmem

---
 rtl/embertrail_pkg.sv | 15 +
 rtl/embertrail_dmem_ram.sv | 34 +++
 rtl/embertrail_dmem.sv | 133 +++++++++++++
 tb/tb_embertrail_dmem.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/embertrail_pkg.sv
// embertrail_pkg: shared types and constants for the embertrail data memory.
//   DATA_W / NUM_LANES : word width and number of independent access lanes
//   MEM_READ/MEM_WRITE : encoding of the per-lane RW strobe
//   state_e            : controller states (CLEAR sweeps the array, RUN serves requests)
package embertrail_pkg;
  localparam int   DATA_W    = 16;
  localparam int   NUM_LANES = 2;
  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;
endpackage

// File: rtl/embertrail_dmem_ram.sv
// embertrail_dmem_ram: 2-write / 2-read register array, no reset on storage.
//   clk_i   : rising-edge clock
//   we_i    : per-lane write enable
//   waddr_i : per-lane write word address
//   wdata_i : per-lane write data
//   raddr_i : per-lane read word address
//   rdata_o : per-lane asynchronous read data (pre-edge contents)
// Reads are combinational, so a same-cycle write to the read address is only
// visible after the edge: the caller registers old data (read-before-write).
// Writes are issued in lane order, so the higher lane wins an address collision.
module embertrail_dmem_ram
  import embertrail_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic                               clk_i,
  input  logic [NUM_LANES-1:0]               we_i,
  input  logic [NUM_LANES-1:0][AW-1:0]       waddr_i,
  input  logic [NUM_LANES-1:0][DATA_W-1:0]   wdata_i,
  input  logic [NUM_LANES-1:0][AW-1:0]       raddr_i,
  output logic [NUM_LANES-1:0][DATA_W-1:0]   rdata_o
);
  logic [DATA_W-1:0] mem_q [2**AW];

  // last NBA to the same word wins -> lane 2 beats lane 1
  always_ff @(posedge clk_i) begin
    for (int l = 0; l < NUM_LANES; l++)
      if (we_i[l]) mem_q[waddr_i[l]] <= wdata_i[l];
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_rd
    assign rdata_o[l] = mem_q[raddr_i[l]];
  end
endmodule

// File: rtl/embertrail_dmem.sv
// embertrail_dmem: dual-lane 16-bit data memory with power-on clear sweep.
//   iClock        : rising-edge clock
//   iReset        : asynchronous active-high reset
//   iDataAddrBus  : {lane2 addr, lane1 addr} word addresses
//   iDataDataBus  : {lane2 wdata, lane1 wdata}
//   iData1/2BusEn : per-lane request enable
//   iDataMem1/2RW : per-lane direction (1 write, 0 read)
//   oDataDataBus  : {lane2 rdata, lane1 rdata}, registered, held between reads
//   oData1/2Valid : one-cycle read-data-valid pulse
//   oAddrError    : per-lane out-of-range pulse, bit0 = lane 1
//   oReady        : high while requests are accepted (RUN)
module embertrail_dmem
  import embertrail_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [31:0] iDataAddrBus,
  input  logic [31:0] iDataDataBus,
  input  logic        iData1BusEn,
  input  logic        iData2BusEn,
  input  logic        iDataMem1RW,
  input  logic        iDataMem2RW,
  output logic [31:0] oDataDataBus,
  output logic        oData1Valid,
  output logic        oData2Valid,
  output logic [1:0]  oAddrError,
  output logic        oReady
);
  localparam int            AW        = DEPTH_LOG2;
  localparam logic [AW-1:0] CNT_LAST  = AW'((2**AW) - 2);
  localparam state_e        RST_STATE = INIT_CLEAR ? CLEAR : RUN;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  logic [NUM_LANES-1:0][DATA_W-1:0] addr, wdata;
  logic [NUM_LANES-1:0]             en, rw, in_rng, rd_req, err_req;
  logic [NUM_LANES-1:0]             ram_we;
  logic [NUM_LANES-1:0][AW-1:0]     ram_waddr, ram_raddr;
  logic [NUM_LANES-1:0][DATA_W-1:0] ram_wdata, ram_rdata;
  logic [NUM_LANES-1:0][DATA_W-1:0] rdata_q;
  logic [NUM_LANES-1:0]             vld_q, err_q;

  assign addr  = iDataAddrBus;
  assign wdata = iDataDataBus;
  assign en    = {iData2BusEn, iData1BusEn};
  assign rw    = {iDataMem2RW, iDataMem1RW};

  // ---- controller ----
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + AW'(2);
        if (cnt_q == CNT_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
  end

  // ---- per-lane request decode / clear sweep muxing ----
  always_comb begin
    in_rng    = '0;
    rd_req    = '0;
    err_req   = '0;
    ram_we    = '0;
    ram_waddr = '0;
    ram_wdata = '0;
    ram_raddr = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      in_rng[l]    = (addr[l] >> AW) == '0;
      ram_raddr[l] = addr[l][AW-1:0];
      if (state_q == RUN) begin
        rd_req[l]    = en[l] && (rw[l] == MEM_READ);
        err_req[l]   = en[l] && !in_rng[l];
        ram_we[l]    = en[l] && (rw[l] == MEM_WRITE) && in_rng[l];
        ram_waddr[l] = addr[l][AW-1:0];
        ram_wdata[l] = wdata[l];
      end else begin
        // lane l zeroes word cnt+l, so the sweep covers two words per cycle
        ram_we[l]    = 1'b1;
        ram_waddr[l] = cnt_q + AW'(l);
      end
    end
  end

  embertrail_dmem_ram #(.AW(AW)) u_ram (
    .clk_i   (iClock),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // ---- output registers ----
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      rdata_q <= '0;
      vld_q   <= '0;
      err_q   <= '0;
    end else begin
      vld_q <= rd_req;
      err_q <= err_req;
      for (int l = 0; l < NUM_LANES; l++)
        if (rd_req[l]) rdata_q[l] <= in_rng[l] ? ram_rdata[l] : '0;
    end
  end

  assign oDataDataBus = rdata_q;
  assign oData1Valid  = vld_q[0];
  assign oData2Valid  = vld_q[1];
  assign oAddrError   = err_q;
  // gated with iReset so the no-clear build still reports not-ready while held
  assign oReady       = (state_q == RUN) && !iReset;
endmodule

// File: tb/tb_embertrail_dmem.sv
module tb_embertrail_dmem;
  localparam int DL    = 8;
  localparam int DEPTH = 1 << DL;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr_bus = '0, wdata_bus = '0, rdata_bus;
  logic        en1 = 1'b0, en2 = 1'b0, rw1 = 1'b0, rw2 = 1'b0;
  logic        v1, v2, rdy;
  logic [1:0]  aerr;

  embertrail_dmem #(.DEPTH_LOG2(DL), .INIT_CLEAR(1'b1)) dut (
    .iClock       (clk),
    .iReset       (rst),
    .iDataAddrBus (addr_bus),
    .iDataDataBus (wdata_bus),
    .iData1BusEn  (en1),
    .iData2BusEn  (en2),
    .iDataMem1RW  (rw1),
    .iDataMem2RW  (rw2),
    .oDataDataBus (rdata_bus),
    .oData1Valid  (v1),
    .oData2Valid  (v2),
    .oAddrError   (aerr),
    .oReady       (rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          vld;
    bit          err;
    logic [15:0] data;
  } exp_t;

  exp_t        q1[$], q2[$];
  logic [15:0] mem [DEPTH];
  logic [15:0] last1 = '0, last2 = '0;
  int          n_cmp = 0, n_fail = 0;
  bit          run = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Scoreboard: each request pushed before edge k must appear right after edge k.
  task automatic mon_lane(input int l, input bit v, input bit e, input logic [15:0] d);
    exp_t        x;
    bit          have;
    logic [15:0] lst;
    lst  = (l == 0) ? last1 : last2;
    have = 1'b0;
    if (l == 0 && q1.size() > 0) begin x = q1.pop_front(); have = 1'b1; end
    if (l == 1 && q2.size() > 0) begin x = q2.pop_front(); have = 1'b1; end
    if (!have) begin x.vld = 1'b0; x.err = 1'b0; x.data = lst; end
    else if (!x.vld) x.data = lst;
    n_cmp++;
    if (v !== x.vld || e !== x.err || d !== x.data) begin
      n_fail++;
      $display("FAIL lane%0d_out @%0t: got vld=%0b err=%0b data=%h, want vld=%0b err=%0b data=%h",
               l + 1, $time, v, e, d, x.vld, x.err, x.data);
    end
    if (x.vld) begin
      if (l == 0) last1 = x.data; else last2 = x.data;
    end
  endtask

  initial forever begin
    @(posedge clk); #1;
    if (rst) begin
      last1 = '0;
      last2 = '0;
    end else begin
      mon_lane(0, v1, aerr[0], rdata_bus[15:0]);
      mon_lane(1, v2, aerr[1], rdata_bus[31:16]);
    end
  end

  // Reference model: reads see pre-cycle contents, then lane 1 writes, then lane 2.
  task automatic cyc(input bit e1, input bit w1, input logic [15:0] a1, input logic [15:0] d1,
                     input bit e2, input bit w2, input logic [15:0] a2, input logic [15:0] d2);
    exp_t x;
    bit   ok1, ok2;
    @(negedge clk);
    en1 = e1; rw1 = w1; en2 = e2; rw2 = w2;
    addr_bus  = {a2, a1};
    wdata_bus = {d2, d1};
    if (run) begin
      ok1 = a1 < DEPTH;
      ok2 = a2 < DEPTH;
      if (e1 && (!w1 || !ok1)) begin
        x.vld = !w1; x.err = !ok1; x.data = ok1 ? mem[a1[DL-1:0]] : 16'h0000;
        q1.push_back(x);
      end
      if (e2 && (!w2 || !ok2)) begin
        x.vld = !w2; x.err = !ok2; x.data = ok2 ? mem[a2[DL-1:0]] : 16'h0000;
        q2.push_back(x);
      end
      if (e1 && w1 && ok1) mem[a1[DL-1:0]] = d1;
      if (e2 && w2 && ok2) mem[a2[DL-1:0]] = d2;
    end
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  function automatic logic [15:0] rnd_addr();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return 16'($urandom);
    if (r == 1) return 16'($urandom_range(256, 300));
    return 16'($urandom_range(0, 31));
  endfunction

  task automatic rnd_inputs();
    en1 = 1'($urandom); en2 = 1'($urandom);
    rw1 = 1'($urandom); rw2 = 1'($urandom);
    addr_bus  = {rnd_addr(), rnd_addr()};
    wdata_bus = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    q1.delete();
    q2.delete();
    foreach (mem[i]) mem[i] = 16'h0000;
    en1 = 1'b0; en2 = 1'b0;
    #1;
    check("rst_data",  rdata_bus, 32'h0);
    check("rst_valid", {30'h0, v2, v1}, 32'h0);
    check("rst_aerr",  {30'h0, aerr}, 32'h0);
    check("rst_ready", {31'h0, rdy}, 32'h0);
    repeat (2) @(posedge clk);
  endtask

  // Releases reset, throws random requests at the clear sweep, and counts edges to ready.
  task automatic release_and_wait();
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    while (!seen && n < 400) begin
      rnd_inputs();
      @(posedge clk); #1;
      n++;
      if (rdy) seen = 1'b1;
      else @(negedge clk);
    end
    check("ready_cycles", n, 32'd128);
    @(negedge clk);
    en1 = 1'b0; en2 = 1'b0; rw1 = 1'b0; rw2 = 1'b0;
    addr_bus = '0; wdata_bus = '0;
    run = seen;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    release_and_wait();

    // freshly cleared memory reads zero; both lanes on one address agree
    cyc(1, 0, 16'h00FF, 16'h0, 1, 0, 16'h0000, 16'h0);
    cyc(1, 0, 16'h0080, 16'h0, 1, 0, 16'h0080, 16'h0);
    // write on lane 1, read back on lane 2
    cyc(1, 1, 16'h0010, 16'hBEEF, 0, 0, 16'h0, 16'h0);
    cyc(0, 0, 16'h0, 16'h0, 1, 0, 16'h0010, 16'h0);
    idle();
    // same-address double write: lane 2 wins
    cyc(1, 1, 16'h0020, 16'h1111, 1, 1, 16'h0020, 16'h2222);
    cyc(1, 0, 16'h0020, 16'h0, 1, 0, 16'h0020, 16'h0);
    // read-before-write across lanes
    cyc(1, 1, 16'h0030, 16'h00AA, 0, 0, 16'h0, 16'h0);
    cyc(1, 0, 16'h0030, 16'h0, 1, 1, 16'h0030, 16'h00BB);
    cyc(1, 0, 16'h0030, 16'h0, 0, 0, 16'h0, 16'h0);
    // out-of-range read/write; 0x0100 aliases 0x0000 in the low bits
    cyc(0, 0, 16'h0, 16'h0, 1, 0, 16'h0100, 16'h0);
    cyc(1, 1, 16'h0100, 16'h5555, 0, 0, 16'h0, 16'h0);
    cyc(1, 0, 16'h0000, 16'h0, 1, 0, 16'hFFFF, 16'h0);
    // disabled lanes ignore RW and data
    cyc(0, 1, 16'h0040, 16'h1234, 0, 1, 16'h0041, 16'h5678);
    cyc(1, 0, 16'h0040, 16'h0, 1, 0, 16'h0041, 16'h0);

    repeat (600)
      cyc(1'($urandom), 1'($urandom), rnd_addr(), 16'($urandom),
          1'($urandom), 1'($urandom), rnd_addr(), 16'($urandom));
    idle();

    // reset in the middle of the clear sweep
    do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #3;
    do_reset();
    release_and_wait();

    // reset while a read result is being presented
    cyc(1, 1, 16'h0010, 16'hCAFE, 0, 0, 16'h0, 16'h0);
    cyc(1, 0, 16'h0010, 16'h0, 1, 0, 16'h0010, 16'h0);
    @(posedge clk);
    #3;
    do_reset();
    release_and_wait();
    cyc(1, 0, 16'h0010, 16'h0, 1, 0, 16'h0011, 16'h0);

    repeat (100)
      cyc(1'($urandom), 1'($urandom), rnd_addr(), 16'($urandom),
          1'($urandom), 1'($urandom), rnd_addr(), 16'($urandom));
    idle();
    idle();
    @(posedge clk); #2;
    check("drain_q1", q1.size(), 32'd0);
    check("drain_q2", q2.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
    $finish;
  end
endmodule
